// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC generation, in-order imem requests with credit-based flow
// control, show-ahead instruction buffer toward decode, and redirect flush/refetch.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   pc;
  logic [CW-1:0] inflight;
  logic [CW-1:0] kill;
  logic [CW-1:0] count;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] pq_rd;
  logic [AW-1:0] pq_wr;

  logic [31:0] fifo_data [FIFO_DEPTH];
  logic [31:0] fifo_pc   [FIFO_DEPTH];
  logic [31:0] pc_q      [FIFO_DEPTH];

  logic [CW:0] occupancy;
  logic        req_fire;
  logic        resp_fire;
  logic        push;
  logic        pop;

  // Credit rule: never have more requests outstanding than free buffer slots.
  assign occupancy      = {1'b0, inflight} + {1'b0, count};
  assign imem_req_valid = reset && (occupancy < (CW+1)'(FIFO_DEPTH)) && !redirect_valid;
  assign imem_req_addr  = pc;

  assign req_fire  = imem_req_valid && imem_req_ready;
  assign resp_fire = imem_resp_valid && (inflight != '0);
  assign push      = resp_fire && (kill == '0) && !redirect_valid;

  assign instr_valid = (count != '0);
  assign pop         = instr_valid && instr_ready && !redirect_valid;
  assign instr       = instr_valid ? fifo_data[rd_ptr] : '0;
  assign instr_pc    = instr_valid ? fifo_pc[rd_ptr]   : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc       <= RESET_PC;
      inflight <= '0;
      kill     <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      pq_rd    <= '0;
      pq_wr    <= '0;
    end else begin
      inflight <= inflight + CW'(req_fire) - CW'(resp_fire);
      if (req_fire)  pq_wr <= pq_wr + AW'(1);
      if (resp_fire) pq_rd <= pq_rd + AW'(1);

      if (redirect_valid) begin
        pc     <= {redirect_pc[31:2], 2'b00};
        // Every response still outstanding after this cycle belongs to the old path.
        kill   <= inflight - CW'(resp_fire);
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (req_fire) pc <= pc + 32'd4;
        if (resp_fire && (kill != '0)) kill <= kill - CW'(1);
        count <= count + CW'(push) - CW'(pop);
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // Storage needs no reset: reads are gated by the counters above.
  always_ff @(posedge clock) begin
    if (req_fire) pc_q[pq_wr] <= pc;
    if (push) begin
      fifo_data[wr_ptr] <= imem_resp_data;
      fifo_pc[wr_ptr]   <= pc_q[pq_rd];
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: latency-configurable memory model, PC model with a scoreboard of
// PCs expected at decode, a redirect vector table and hand-written stall/reset sequences.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clock = 0;
  logic        reset = 0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 0;
  logic [31:0] imem_resp_data = 0;
  logic        redirect_valid = 0;
  logic [31:0] redirect_pc = 0;
  logic        instr_valid;
  logic        instr_ready = 1;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  fetch_stage #(.RESET_PC(RESET_PC), .FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    logic [31:0] target;
    int          lat;
    logic [31:0] exp_addr;
  } redir_vec_t;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          mem_lat = 1;
  int          outstanding = 0;
  logic [31:0] model_pc = RESET_PC;
  logic [31:0] exp_q[$];
  pend_t       pend[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic redirect(input logic [31:0] t);
    @(posedge clock);
    #1;
    redirect_valid = 1;
    redirect_pc = t;
    @(posedge clock);
    #1;
    redirect_valid = 0;
  endtask

  task automatic drain(input string name);
    int n;
    imem_req_ready = 0;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk(name, exp_q.size(), 0);
    step(1);
    imem_req_ready = 1;
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Memory: in-order responses, data = address, mem_lat cycles after acceptance.
  always @(posedge clock) begin
    #1;
    imem_resp_valid = 0;
    imem_resp_data = 0;
    if (reset && pend.size() > 0 && pend[0].due <= cyc) begin
      assert (outstanding > 0) else $error("response driven with nothing outstanding");
      imem_resp_valid = 1;
      imem_resp_data = pend[0].addr;
      void'(pend.pop_front());
      outstanding--;
    end
  end

  // Request tracking, PC model and decode-side scoreboard.
  always @(negedge clock) begin
    logic [31:0] e;
    if (!reset) begin
      exp_q.delete();
      pend.delete();
      outstanding = 0;
      model_pc = RESET_PC;
    end else if (redirect_valid) begin
      chk("req_valid_in_redirect", {31'b0, imem_req_valid}, 32'd0);
      exp_q.delete();
      model_pc = {redirect_pc[31:2], 2'b00};
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        chk("req_addr", imem_req_addr, model_pc);
        exp_q.push_back(model_pc);
        pend.push_back('{addr: imem_req_addr, due: cyc + mem_lat});
        outstanding++;
        model_pc = model_pc + 32'd4;
      end
      if (instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_instr act=%h exp=none t=%0t", instr_pc, $time);
        end else begin
          e = exp_q.pop_front();
          chk("instr_pc", instr_pc, e);
          chk("instr", instr, e);
        end
      end
    end
  end

  redir_vec_t vecs[4];

  initial begin
    vecs[0] = '{target: 32'h0000_0100, lat: 3, exp_addr: 32'h0000_0100};
    vecs[1] = '{target: 32'h0000_0103, lat: 1, exp_addr: 32'h0000_0100};
    vecs[2] = '{target: 32'hFFFF_FFFC, lat: 1, exp_addr: 32'hFFFF_FFFC};
    vecs[3] = '{target: 32'h0000_0046, lat: 2, exp_addr: 32'h0000_0044};

    #2;
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_req_addr", imem_req_addr, RESET_PC);
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    step(3);
    reset = 1;
    @(negedge clock);
    chk("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("first_req_addr", imem_req_addr, RESET_PC);

    // Streaming, then a decode stall long enough to fill the buffer.
    step(12);
    instr_ready = 0;
    step(10);
    @(negedge clock);
    chk("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("stall_instr_valid", {31'b0, instr_valid}, 32'd1);
    chk("stall_buffered", exp_q.size(), 32'd4);
    step(1);
    instr_ready = 1;
    step(8);
    drain("drain_stall");

    // Redirect vectors.
    for (int i = 0; i < 4; i++) begin
      mem_lat = vecs[i].lat;
      step(6);
      redirect(vecs[i].target);
      @(negedge clock);
      chk($sformatf("redir_addr_%0d", i), imem_req_addr, vecs[i].exp_addr);
      step(6);
      drain($sformatf("drain_redir_%0d", i));
    end

    // Second redirect while the first path's responses are still in flight.
    mem_lat = 3;
    step(6);
    redirect(32'h0000_0300);
    redirect(32'h0000_0200);
    @(negedge clock);
    chk("double_redir_addr", imem_req_addr, 32'h0000_0200);
    step(8);
    drain("drain_double");

    // Reset asserted mid-stream with the buffer partly full.
    mem_lat = 1;
    step(6);
    instr_ready = 0;
    step(2);
    #2;
    reset = 0;
    #1;
    chk("midrst_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("midrst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("midrst_req_addr", imem_req_addr, RESET_PC);
    step(2);
    reset = 1;
    instr_ready = 1;
    step(8);
    drain("drain_reset");

    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
